mem_port_master: RTL

- Initiator side of the single-port byte RAM.
- Arbitrates the instruction-fetch client (10-byte Y86 instructions) and the data-memory client (8-byte load/store) onto one RAM port.
- Drives the RAM read/write/instruction-select strobes and captures the combinational read data into registers.
- Returns a one-cycle ack, with data and an error flag, to the granted client.

---
 rtl/mem_port_master_if.sv | 39 +++
 rtl/mem_port_master.sv | 111 +++++++++++
 2 files changed

// File: rtl/mem_port_master_if.sv
// rtl/mem_port_master_if.sv - client and RAM-side signal bundle for mem_port_master
interface mem_port_master_if #(
  parameter int AW = 64
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [79:0]   if_instr;
  logic          if_err;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [63:0]   dm_wdata;
  logic          dm_ack;
  logic [63:0]   dm_rdata;
  logic          dm_err;
  logic          ram_read_en;
  logic          ram_write_en;
  logic          ram_read_instruction_en;
  logic [AW-1:0] ram_addr;
  logic [63:0]   ram_write_data;
  logic [63:0]   ram_read_data;
  logic [79:0]   ram_read_instruction;
  logic          ram_error;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
    input  ram_read_data, ram_read_instruction, ram_error,
    output if_ack, if_instr, if_err, dm_ack, dm_rdata, dm_err,
    output ram_read_en, ram_write_en, ram_read_instruction_en, ram_addr, ram_write_data
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
    output ram_read_data, ram_read_instruction, ram_error,
    input  if_ack, if_instr, if_err, dm_ack, dm_rdata, dm_err,
    input  ram_read_en, ram_write_en, ram_read_instruction_en, ram_addr, ram_write_data
  );
endinterface

// File: rtl/mem_port_master.sv
// rtl/mem_port_master.sv - arbitrates fetch and data clients onto one single-port byte RAM
// Build option MEM_ARB_RR_EN: round-robin tie-break instead of fixed data-first priority.
module mem_port_master #(
  parameter int ADDR_MAX = 1023,
  parameter int AW = 64
) (
  input logic               clk_i,
  input logic               rst_n_i,
  mem_port_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [AW-1:0] DM_LIM = AW'(ADDR_MAX - 7);
  localparam logic [AW-1:0] IF_LIM = AW'(ADDR_MAX - 9);

  state_t        state;
  logic          gnt_dm;
  logic          we_q;
  logic          bnd_err;
  logic [AW-1:0] addr_q;
  logic [63:0]   wdata_q;

  logic          any_req;
  logic          pick_dm;
  logic          pick_err;
  logic [AW-1:0] pick_addr;
  logic          acc_err;
  logic          in_access;
  logic          do_write;

  assign any_req = bus.if_req | bus.dm_req;

`ifdef MEM_ARB_RR_EN
  logic last_dm;

  // On a tie the client that lost last time wins; a lone requester always wins.
  assign pick_dm = bus.dm_req && (!bus.if_req || !last_dm);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      last_dm <= 1'b0;
    end else if (state == IDLE && any_req) begin
      last_dm <= pick_dm;
    end
  end
`else
  assign pick_dm = bus.dm_req;
`endif

  // Full-width unsigned compare, so addresses near the top of the space flag rather than wrap.
  assign pick_addr = pick_dm ? bus.dm_addr : bus.if_addr;
  assign pick_err  = pick_dm ? (bus.dm_addr > DM_LIM) : (bus.if_addr > IF_LIM);

  assign acc_err   = bnd_err | bus.ram_error;
  assign in_access = (state == ACCESS) && rst_n_i;
  assign do_write  = in_access && gnt_dm && we_q && !bnd_err;

  assign bus.ram_read_en             = in_access && !(gnt_dm && we_q);
  assign bus.ram_read_instruction_en = in_access && !gnt_dm;
  assign bus.ram_write_en            = do_write;
  assign bus.ram_addr                = in_access ? addr_q : '0;
  assign bus.ram_write_data          = do_write ? wdata_q : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      gnt_dm       <= 1'b0;
      we_q         <= 1'b0;
      bnd_err      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      bus.if_ack   <= 1'b0;
      bus.dm_ack   <= 1'b0;
      bus.if_err   <= 1'b0;
      bus.dm_err   <= 1'b0;
      bus.if_instr <= '0;
      bus.dm_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_dm  <= pick_dm;
            we_q    <= pick_dm && bus.dm_we;
            bnd_err <= pick_err;
            addr_q  <= pick_addr;
            wdata_q <= bus.dm_wdata;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          state <= RESP;
          if (gnt_dm) begin
            bus.dm_ack   <= 1'b1;
            bus.dm_err   <= acc_err;
            bus.dm_rdata <= (acc_err || we_q) ? 64'h0 : bus.ram_read_data;
          end else begin
            bus.if_ack   <= 1'b1;
            bus.if_err   <= acc_err;
            bus.if_instr <= acc_err ? 80'h0 : bus.ram_read_instruction;
          end
        end
        RESP: begin
          bus.if_ack <= 1'b0;
          bus.dm_ack <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
